// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: requester IDs and default widths.
package dmem_arb_pkg;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_e;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_LIM = 4;

endpackage

// File: rtl/dmem_arb_resp.sv
// Per-requester read response: captures memory read data on a granted read and
// pulses rvalid for exactly the following cycle.
module dmem_arb_resp #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_fire,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);

  // rvalid doubles as the rd_pend bit: a read granted last cycle is being returned now.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid <= 1'b0;
      // NOTE: a single data register (not a memory array) is cheap to reset, so it is cleared too.
      rdata  <= '0;
    end else begin
      rvalid <= rd_fire;
      if (rd_fire) rdata <= mem_rdata;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (m0) has fixed priority, loader (m1) gets a
// forced grant after STARVE_LIM consecutive blocked cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = DEF_STARVE_LIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_stall
);

  logic [3:0] wait_cnt;
  logic       force_m1;
  logic       m0_win;
  logic       m1_win;
  req_id_e    winner;

  // Grants are suppressed while reset is held, even with requests pending.
  assign force_m1 = m1_req && (wait_cnt == 4'(STARVE_LIM));
  assign m1_win   = rst && m1_req && (force_m1 || !m0_req);
  assign m0_win   = rst && m0_req && !m1_win;
  assign winner   = m1_win ? REQ_LOAD : REQ_CORE;

  assign m0_gnt     = m0_win;
  assign m1_gnt     = m1_win;
  assign core_stall = m0_req && !m0_win;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_win || m1_win) begin
      case (winner)
        REQ_LOAD: begin
          mem_wr    = m1_we;
          mem_rd    = !m1_we;
          mem_addr  = m1_addr;
          mem_wdata = m1_wdata;
        end
        default: begin
          mem_wr    = m0_we;
          mem_rd    = !m0_we;
          mem_addr  = m0_addr;
          mem_wdata = m0_wdata;
        end
      endcase
    end
  end

  // Counts consecutive cycles m1 is blocked; saturates at the forcing threshold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 4'd0;
    end else if (!m1_req || m1_win) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != 4'(STARVE_LIM)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  dmem_arb_resp #(.DATA_W(DATA_W)) u_resp_core (
    .clk       (clk),
    .rst       (rst),
    .rd_fire   (m0_win && !m0_we),
    .mem_rdata (mem_rdata),
    .rvalid    (m0_rvalid),
    .rdata     (m0_rdata)
  );

  dmem_arb_resp #(.DATA_W(DATA_W)) u_resp_load (
    .clk       (clk),
    .rst       (rst),
    .rd_fire   (m1_win && !m1_we),
    .mem_rdata (mem_rdata),
    .rvalid    (m1_rvalid),
    .rdata     (m1_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written reset
// sequences, and randomized traffic against a behavioural reference model.
module tb_dmem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, mem_wdata, mem_rdata, m0_rdata, m1_rdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_rd, mem_wr, core_stall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .core_stall(core_stall)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          m0_req, m0_we;
    logic [AW-1:0] m0_addr;
    logic          m1_req, m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, mem_rdata;
    logic          e_g0, e_g1, e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_rv0;
    logic [DW-1:0] e_rd0;
    logic          e_rv1;
    logic [DW-1:0] e_rd1;
    logic          e_stall;
  } vec_t;

  function automatic vec_t v(
    input logic r0, w0, input logic [AW-1:0] a0,
    input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] wd1,
    input logic [DW-1:0] mrd,
    input logic g0, g1, rd, wr, input logic [AW-1:0] ea, input logic [DW-1:0] ewd,
    input logic rv0, input logic [DW-1:0] rd0, input logic rv1, input logic [DW-1:0] rd1,
    input logic st);
    vec_t t;
    t.m0_req = r0; t.m0_we = w0; t.m0_addr = a0;
    t.m1_req = r1; t.m1_we = w1; t.m1_addr = a1; t.m1_wdata = wd1; t.mem_rdata = mrd;
    t.e_g0 = g0; t.e_g1 = g1; t.e_rd = rd; t.e_wr = wr; t.e_addr = ea; t.e_wdata = ewd;
    t.e_rv0 = rv0; t.e_rd0 = rd0; t.e_rv1 = rv1; t.e_rd1 = rd1; t.e_stall = st;
    return t;
  endfunction

  vec_t tbl[$];

  // Reference model state: blocked-streak length of m1 and expected response registers.
  int            m_wait;
  logic          x_rv0, x_rv1;
  logic [DW-1:0] x_rd0, x_rd1;

  initial begin
    logic w1, w0;
    // m0 wdata is fixed at 0xC0 throughout the table.
    tbl.push_back(v(1,0,'h10,   0,0,0,0,           'hDEADBEEF, 1,0,1,0,'h10,'hC0,  0,0,          0,0,    0));
    tbl.push_back(v(0,0,0,      0,0,0,0,           0,          0,0,0,0,0,0,        1,'hDEADBEEF, 0,0,    0));
    tbl.push_back(v(0,0,0,      0,0,0,0,           0,          0,0,0,0,0,0,        0,'hDEADBEEF, 0,0,    0));
    tbl.push_back(v(0,0,0,      1,1,'h20,'h5,      0,          0,1,0,1,'h20,'h5,   0,'hDEADBEEF, 0,0,    0));
    tbl.push_back(v(0,0,0,      0,0,0,0,           0,          0,0,0,0,0,0,        0,'hDEADBEEF, 0,0,    0));
    tbl.push_back(v(1,0,'h0,    0,0,0,0,           'hA0,       1,0,1,0,'h0,'hC0,   0,'hDEADBEEF, 0,0,    0));
    tbl.push_back(v(1,0,'h4,    0,0,0,0,           'hA4,       1,0,1,0,'h4,'hC0,   1,'hA0,       0,0,    0));
    tbl.push_back(v(1,0,'h8,    0,0,0,0,           'hA8,       1,0,1,0,'h8,'hC0,   1,'hA4,       0,0,    0));
    tbl.push_back(v(0,0,0,      0,0,0,0,           0,          0,0,0,0,0,0,        1,'hA8,       0,0,    0));
    tbl.push_back(v(0,0,0,      0,0,0,0,           0,          0,0,0,0,0,0,        0,'hA8,       0,0,    0));
    // Both requesting: four m0 grants, then a forced m1 grant, repeating every five cycles.
    tbl.push_back(v(1,0,'h100,  1,0,'h203,'hC1,    'h11,       1,0,1,0,'h100,'hC0, 0,'hA8,       0,0,    0));
    tbl.push_back(v(1,0,'h100,  1,0,'h203,'hC1,    'h11,       1,0,1,0,'h100,'hC0, 1,'h11,       0,0,    0));
    tbl.push_back(v(1,0,'h100,  1,0,'h203,'hC1,    'h11,       1,0,1,0,'h100,'hC0, 1,'h11,       0,0,    0));
    tbl.push_back(v(1,0,'h100,  1,0,'h203,'hC1,    'h11,       1,0,1,0,'h100,'hC0, 1,'h11,       0,0,    0));
    tbl.push_back(v(1,0,'h100,  1,0,'h203,'hC1,    'h11,       0,1,1,0,'h203,'hC1, 1,'h11,       0,0,    1));
    tbl.push_back(v(1,0,'h100,  1,0,'h203,'hC1,    'h11,       1,0,1,0,'h100,'hC0, 0,'h11,       1,'h11, 0));
    tbl.push_back(v(1,0,'h100,  1,0,'h203,'hC1,    'h11,       1,0,1,0,'h100,'hC0, 1,'h11,       0,'h11, 0));
    tbl.push_back(v(1,0,'h100,  1,0,'h203,'hC1,    'h11,       1,0,1,0,'h100,'hC0, 1,'h11,       0,'h11, 0));
    tbl.push_back(v(1,0,'h100,  1,0,'h203,'hC1,    'h11,       1,0,1,0,'h100,'hC0, 1,'h11,       0,'h11, 0));
    tbl.push_back(v(1,0,'h100,  1,0,'h203,'hC1,    'h22,       0,1,1,0,'h203,'hC1, 1,'h11,       0,'h11, 1));
    tbl.push_back(v(0,0,0,      0,0,0,0,           0,          0,0,0,0,0,0,        0,'h11,       1,'h22, 0));

    // Reset held with both requests pending: no grants, no memory command.
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 'h40; m0_wdata = 'hC0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 'h50; m1_wdata = 'hC1; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    rst = 1'b1;
    #1;
    check("rel_m0_gnt", m0_gnt, 1);
    check("rel_m1_gnt", m1_gnt, 0);
    check("rel_mem_wr", mem_wr, 1);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      m0_req = tbl[i].m0_req; m0_we = tbl[i].m0_we; m0_addr = tbl[i].m0_addr; m0_wdata = 'hC0;
      m1_req = tbl[i].m1_req; m1_we = tbl[i].m1_we; m1_addr = tbl[i].m1_addr;
      m1_wdata = tbl[i].m1_wdata; mem_rdata = tbl[i].mem_rdata;
      @(negedge clk);
      check($sformatf("v%0d m0_gnt", i), m0_gnt, tbl[i].e_g0);
      check($sformatf("v%0d m1_gnt", i), m1_gnt, tbl[i].e_g1);
      check($sformatf("v%0d mem_rd", i), mem_rd, tbl[i].e_rd);
      check($sformatf("v%0d mem_wr", i), mem_wr, tbl[i].e_wr);
      check($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_addr);
      check($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].e_wdata);
      check($sformatf("v%0d m0_rvalid", i), m0_rvalid, tbl[i].e_rv0);
      check($sformatf("v%0d m0_rdata", i), m0_rdata, tbl[i].e_rd0);
      check($sformatf("v%0d m1_rvalid", i), m1_rvalid, tbl[i].e_rv1);
      check($sformatf("v%0d m1_rdata", i), m1_rdata, tbl[i].e_rd1);
      check($sformatf("v%0d core_stall", i), core_stall, tbl[i].e_stall);
      @(posedge clk); #1;
    end

    // Reset asserted in the cycle after a granted read: the pending rvalid is dropped.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 'h30; m1_req = 1'b0; mem_rdata = 'h77;
    @(negedge clk);
    check("mid_m0_gnt", m0_gnt, 1);
    @(posedge clk); #1;
    m0_req = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rvalid_now", m0_rvalid, 0);
    check("mid_rdata_now", m0_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rvalid_after", m0_rvalid, 0);
    check("mid_m1_rvalid_after", m1_rvalid, 0);
    @(posedge clk); #1;

    // Randomized traffic against the reference model, starting from post-reset state.
    m_wait = 0; x_rv0 = 1'b0; x_rv1 = 1'b0; x_rd0 = '0; x_rd1 = '0;
    for (int c = 0; c < 400; c++) begin
      m0_req = ($urandom_range(3) != 0); m0_we = $urandom_range(1); m0_addr = $urandom(); m0_wdata = $urandom();
      m1_req = ($urandom_range(3) != 0); m1_we = $urandom_range(1); m1_addr = $urandom(); m1_wdata = $urandom();
      mem_rdata = $urandom();
      // m1 wins if it has waited out the limit or the core is idle; the core takes anything else.
      w1 = m1_req && (m_wait >= LIM || !m0_req);
      w0 = m0_req && !w1;
      @(negedge clk);
      check($sformatf("r%0d m0_gnt", c), m0_gnt, w0);
      check($sformatf("r%0d m1_gnt", c), m1_gnt, w1);
      check($sformatf("r%0d mem_rd", c), mem_rd, (w0 && !m0_we) || (w1 && !m1_we));
      check($sformatf("r%0d mem_wr", c), mem_wr, (w0 && m0_we) || (w1 && m1_we));
      check($sformatf("r%0d mem_addr", c), mem_addr, w1 ? m1_addr : (w0 ? m0_addr : '0));
      check($sformatf("r%0d mem_wdata", c), mem_wdata, w1 ? m1_wdata : (w0 ? m0_wdata : '0));
      check($sformatf("r%0d core_stall", c), core_stall, m0_req && !w0);
      check($sformatf("r%0d m0_rvalid", c), m0_rvalid, x_rv0);
      check($sformatf("r%0d m0_rdata", c), m0_rdata, x_rd0);
      check($sformatf("r%0d m1_rvalid", c), m1_rvalid, x_rv1);
      check($sformatf("r%0d m1_rdata", c), m1_rdata, x_rd1);
      m_wait = (m1_req && !w1) ? ((m_wait < LIM) ? m_wait + 1 : LIM) : 0;
      x_rv0 = w0 && !m0_we;
      x_rv1 = w1 && !m1_we;
      if (x_rv0) x_rd0 = mem_rdata;
      if (x_rv1) x_rd1 = mem_rdata;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
